// File: rtl/wqe_fmt_pkg.sv
// Shared WQE layout, opcode constants and segmenter state encoding.
// The WQE cache takes its QPID/WRID offsets from here as well.
package wqe_fmt_pkg;

  localparam int WRID_LSB   = 0;
  localparam int WRID_MSB   = 63;
  localparam int RADDR_LSB  = 64;
  localparam int RADDR_MSB  = 127;
  localparam int LADDR_LSB  = 128;
  localparam int LADDR_MSB  = 191;
  localparam int LEN_LSB    = 192;
  localparam int LEN_MSB    = 223;
  localparam int OPCODE_LSB = 224;
  localparam int OPCODE_MSB = 231;
  localparam int QPID_LSB   = 328;

  localparam logic [7:0] OP_SEND       = 8'h00;
  localparam logic [7:0] OP_SEND_IMM   = 8'h01;
  localparam logic [7:0] OP_RDMA_WRITE = 8'h08;
  localparam logic [7:0] OP_RDMA_READ  = 8'h10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEG  = 2'd2
  } state_t;

endpackage

// File: rtl/wqe_segmenter_if.sv
// Cache read port and packet-descriptor port of the WQE segmenter.
interface wqe_segmenter_if #(
  parameter int WQE_WIDTH    = 512,
  parameter int QP_PTR_WIDTH = 4,
  parameter int MTU_LOG2     = 12
);
  logic                    i_wqe_cache_empty;
  logic                    o_wqe_cache_rd;
  logic                    i_wqe_val;
  logic [WQE_WIDTH-1:0]    i_wqe;

  // Descriptor transfers on a cycle where o_pkt_val & i_pkt_rdy; while val is
  // high and rdy low all o_pkt_* fields hold; rdy without val means nothing.
  logic                    o_pkt_val;
  logic                    i_pkt_rdy;
  logic [QP_PTR_WIDTH-1:0] o_pkt_qpn;
  logic [7:0]              o_pkt_opcode;
  logic [63:0]             o_pkt_laddr;
  logic [63:0]             o_pkt_raddr;
  logic [MTU_LOG2:0]       o_pkt_len;
  logic                    o_pkt_first;
  logic                    o_pkt_last;
  logic [63:0]             o_pkt_wrid;

  modport master (
    input  i_wqe_cache_empty, i_wqe_val, i_wqe, i_pkt_rdy,
    output o_wqe_cache_rd, o_pkt_val, o_pkt_qpn, o_pkt_opcode, o_pkt_laddr,
           o_pkt_raddr, o_pkt_len, o_pkt_first, o_pkt_last, o_pkt_wrid
  );

  modport slave (
    output i_wqe_cache_empty, i_wqe_val, i_wqe, i_pkt_rdy,
    input  o_wqe_cache_rd, o_pkt_val, o_pkt_qpn, o_pkt_opcode, o_pkt_laddr,
           o_pkt_raddr, o_pkt_len, o_pkt_first, o_pkt_last, o_pkt_wrid
  );
endinterface

// File: rtl/wqe_seg_calc.sv
// Segment length, last flag and post-segment remainder/addresses for one MTU step.
module wqe_seg_calc #(
  parameter int MTU_LOG2 = 12
) (
  input  logic [31:0]       rem,
  input  logic [63:0]       laddr,
  input  logic [63:0]       raddr,
  output logic [MTU_LOG2:0] len,
  output logic              last,
  output logic [31:0]       rem_nxt,
  output logic [63:0]       laddr_nxt,
  output logic [63:0]       raddr_nxt
);
  localparam logic [31:0] MTU_BYTES = 32'(1) << MTU_LOG2;

  assign last      = (rem <= MTU_BYTES);
  assign len       = last ? rem[MTU_LOG2:0] : MTU_BYTES[MTU_LOG2:0];
  // len never exceeds rem, so the remainder cannot underflow.
  assign rem_nxt   = rem - 32'(len);
  assign laddr_nxt = laddr + 64'(len);
  assign raddr_nxt = raddr + 64'(len);
endmodule

// File: rtl/wqe_segmenter.sv
// Pops one WQE from the cache and emits it as a run of MTU-sized packet descriptors.
module wqe_segmenter
  import wqe_fmt_pkg::*;
#(
  parameter int WQE_WIDTH    = 512,
  parameter int QP_PTR_WIDTH = 4,
  parameter int MTU_LOG2     = 12
) (
  input  logic  clk,
  input  logic  rst_n,
  wqe_segmenter_if.master bus,
  output logic  o_busy,
  output state_t state_dbg
);
  state_t                  state_q, state_d;
  logic                    rd_q, rd_d;
  logic                    load, advance;
  logic [31:0]             rem_q;
  logic [63:0]             laddr_q, raddr_q, wrid_q;
  logic [7:0]              opcode_q;
  logic [QP_PTR_WIDTH-1:0] qpn_q;
  logic                    first_q;

  logic [MTU_LOG2:0]       seg_len;
  logic                    seg_last;
  logic [31:0]             rem_nxt;
  logic [63:0]             laddr_nxt, raddr_nxt;
  logic                    seg;
  logic                    unused_wqe_bits;

  assign unused_wqe_bits = ^{bus.i_wqe[QPID_LSB-1:OPCODE_MSB+1],
                             bus.i_wqe[WQE_WIDTH-1:QPID_LSB+QP_PTR_WIDTH]};

  wqe_seg_calc #(.MTU_LOG2(MTU_LOG2)) u_calc (
    .rem       (rem_q),
    .laddr     (laddr_q),
    .raddr     (raddr_q),
    .len       (seg_len),
    .last      (seg_last),
    .rem_nxt   (rem_nxt),
    .laddr_nxt (laddr_nxt),
    .raddr_nxt (raddr_nxt)
  );

  always_comb begin
    state_d = state_q;
    rd_d    = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.i_wqe_cache_empty) begin
          rd_d    = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.i_wqe_val) begin
          load    = 1'b1;
          state_d = ST_SEG;
        end
      end
      ST_SEG: begin
        if (bus.i_pkt_rdy) begin
          advance = 1'b1;
          // Always return through IDLE, so the next read trails the last handshake.
          if (seg_last) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      laddr_q  <= '0;
      raddr_q  <= '0;
      wrid_q   <= '0;
      opcode_q <= '0;
      qpn_q    <= '0;
      first_q  <= 1'b0;
    end else if (load) begin
      rem_q    <= bus.i_wqe[LEN_MSB:LEN_LSB];
      laddr_q  <= bus.i_wqe[LADDR_MSB:LADDR_LSB];
      raddr_q  <= bus.i_wqe[RADDR_MSB:RADDR_LSB];
      wrid_q   <= bus.i_wqe[WRID_MSB:WRID_LSB];
      opcode_q <= bus.i_wqe[OPCODE_MSB:OPCODE_LSB];
      qpn_q    <= bus.i_wqe[QPID_LSB +: QP_PTR_WIDTH];
      first_q  <= 1'b1;
    end else if (advance) begin
      rem_q    <= rem_nxt;
      laddr_q  <= laddr_nxt;
      raddr_q  <= raddr_nxt;
      first_q  <= 1'b0;
    end
  end

  // Descriptor fields are forced to zero outside SEG so idle/reset outputs read 0.
  assign seg              = (state_q == ST_SEG);
  assign bus.o_wqe_cache_rd = rd_q;
  assign bus.o_pkt_val    = seg;
  assign bus.o_pkt_qpn    = seg ? qpn_q    : '0;
  assign bus.o_pkt_opcode = seg ? opcode_q : '0;
  assign bus.o_pkt_laddr  = seg ? laddr_q  : '0;
  assign bus.o_pkt_raddr  = seg ? raddr_q  : '0;
  assign bus.o_pkt_len    = seg ? seg_len  : '0;
  assign bus.o_pkt_first  = seg & first_q;
  assign bus.o_pkt_last   = seg & seg_last;
  assign bus.o_pkt_wrid   = seg ? wrid_q   : '0;
  assign o_busy           = (state_q != ST_IDLE);
  assign state_dbg        = state_q;
endmodule

// File: tb/tb_wqe_segmenter.sv
// Directed bench for wqe_segmenter: cache model, descriptor monitor, scenario tasks.
module tb_wqe_segmenter;
  import wqe_fmt_pkg::*;

  localparam int WQE_WIDTH = 512;
  localparam int QPW       = 4;
  localparam int MTU_LOG2  = 12;

  typedef struct packed {
    logic [QPW-1:0]    qpn;
    logic [7:0]        opcode;
    logic [63:0]       laddr;
    logic [63:0]       raddr;
    logic [MTU_LOG2:0] len;
    logic              first;
    logic              last;
    logic [63:0]       wrid;
  } desc_t;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   busy;
  state_t state_dbg;

  wqe_segmenter_if #(.WQE_WIDTH(WQE_WIDTH), .QP_PTR_WIDTH(QPW), .MTU_LOG2(MTU_LOG2)) bus ();

  wqe_segmenter #(.WQE_WIDTH(WQE_WIDTH), .QP_PTR_WIDTH(QPW), .MTU_LOG2(MTU_LOG2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .o_busy    (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- cache model: data valid one cycle after the read strobe ----
  logic [WQE_WIDTH-1:0] cache_q[$];
  logic [WQE_WIDTH-1:0] staged;
  logic                 pending = 1'b0;
  int                   rd_cycles[$];

  initial begin
    bus.i_wqe_val         = 1'b0;
    bus.i_wqe             = '0;
    bus.i_wqe_cache_empty = 1'b1;
    bus.i_pkt_rdy         = 1'b0;
    staged                = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pending       = 1'b0;
        bus.i_wqe_val = 1'b0;
      end else begin
        bus.i_wqe_val = pending;
        if (pending) bus.i_wqe = staged;
        pending = bus.o_wqe_cache_rd;
        if (bus.o_wqe_cache_rd) begin
          rd_cycles.push_back(cyc);
          staged = (cache_q.size() > 0) ? cache_q.pop_front() : '0;
        end
      end
      bus.i_wqe_cache_empty = (cache_q.size() == 0);
    end
  end

  // ---------------- descriptor monitor ----------------
  desc_t got_q[$];
  int    last_cycles[$];
  int    wait_cycles = 0;
  int    wait_err = 0;

  function automatic desc_t cur_desc();
    desc_t d;
    d.qpn    = bus.o_pkt_qpn;
    d.opcode = bus.o_pkt_opcode;
    d.laddr  = bus.o_pkt_laddr;
    d.raddr  = bus.o_pkt_raddr;
    d.len    = bus.o_pkt_len;
    d.first  = bus.o_pkt_first;
    d.last   = bus.o_pkt_last;
    d.wrid   = bus.o_pkt_wrid;
    return d;
  endfunction

  function automatic desc_t mk(input logic [QPW-1:0] q, input logic [7:0] op,
                               input logic [63:0] la, input logic [63:0] ra,
                               input logic [MTU_LOG2:0] len, input logic f,
                               input logic l, input logic [63:0] w);
    desc_t d;
    d.qpn = q; d.opcode = op; d.laddr = la; d.raddr = ra;
    d.len = len; d.first = f; d.last = l; d.wrid = w;
    return d;
  endfunction

  always @(negedge clk) begin
    if (bus.o_pkt_val && bus.i_pkt_rdy) begin
      got_q.push_back(cur_desc());
      if (bus.o_pkt_last) last_cycles.push_back(cyc);
    end
    // A WAIT that outlives the one-cycle read latency means the data never came.
    if (state_dbg == ST_WAIT) wait_cycles++;
    else wait_cycles = 0;
    if (wait_cycles > 3) wait_err = 1;
  end

  // ---------------- driver tasks ----------------
  task automatic push_wqe(input logic [63:0] wrid, input logic [63:0] raddr,
                          input logic [63:0] laddr, input logic [31:0] len,
                          input logic [7:0] op, input logic [QPW-1:0] qpn);
    logic [WQE_WIDTH-1:0] w;
    w = '0;
    w[WRID_MSB:WRID_LSB]     = wrid;
    w[RADDR_MSB:RADDR_LSB]   = raddr;
    w[LADDR_MSB:LADDR_LSB]   = laddr;
    w[LEN_MSB:LEN_LSB]       = len;
    w[OPCODE_MSB:OPCODE_LSB] = op;
    w[QPID_LSB +: QPW]       = qpn;
    w[300]                   = 1'b1;
    cache_q.push_back(w);
  endtask

  task automatic wait_descs(input int base, input int n);
    int k;
    k = 0;
    while (got_q.size() < base + n && k < 300) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_total++;
    if ({bus.o_pkt_val, bus.o_wqe_cache_rd, busy} !== 3'b000)
      $display("FAIL reset_ctrl: got val/rd/busy=%b required 000",
               {bus.o_pkt_val, bus.o_wqe_cache_rd, busy});
    else n_pass++;
    n_total++;
    if (cur_desc() !== desc_t'('0))
      $display("FAIL reset_fields: got %h required 0", cur_desc());
    else n_pass++;
    n_total++;
    if (state_dbg !== ST_IDLE) $display("FAIL reset_state: got %0d required %0d", state_dbg, ST_IDLE);
    else n_pass++;
  endtask

  task automatic test_multi_seg();
    desc_t exp[3];
    int b;
    b = got_q.size();
    bus.i_pkt_rdy = 1'b1;
    push_wqe(64'hA5A5_0000_1111_2222, 64'h0000_0008_0000_0000, 64'h1000, 32'd10000, OP_SEND, 4'd3);
    wait_descs(b, 3);
    wait_idle();
    exp[0] = mk(4'd3, OP_SEND, 64'h1000, 64'h0000_0008_0000_0000, 13'd4096, 1'b1, 1'b0, 64'hA5A5_0000_1111_2222);
    exp[1] = mk(4'd3, OP_SEND, 64'h2000, 64'h0000_0008_0000_1000, 13'd4096, 1'b0, 1'b0, 64'hA5A5_0000_1111_2222);
    exp[2] = mk(4'd3, OP_SEND, 64'h3000, 64'h0000_0008_0000_2000, 13'd1808, 1'b0, 1'b1, 64'hA5A5_0000_1111_2222);
    n_total++;
    if (got_q.size() - b != 3) $display("FAIL multi_seg_count: got %0d required 3", got_q.size() - b);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (got_q.size() <= b + i || got_q[b+i] !== exp[i])
        $display("FAIL multi_seg[%0d]: got %h required %h", i, (got_q.size() > b + i) ? got_q[b+i] : desc_t'('0), exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_exact_mtu();
    desc_t exp[3];
    int b;
    b = got_q.size();
    bus.i_pkt_rdy = 1'b1;
    push_wqe(64'h11, 64'h40000, 64'h20000, 32'd4096, OP_RDMA_WRITE, 4'd5);
    wait_descs(b, 1);
    wait_idle();
    // Second WQE also walks both addresses across the 2^64 wrap.
    push_wqe(64'h22, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_F800, 32'd4097, OP_RDMA_WRITE, 4'd6);
    wait_descs(b, 3);
    wait_idle();
    exp[0] = mk(4'd5, OP_RDMA_WRITE, 64'h20000, 64'h40000, 13'd4096, 1'b1, 1'b1, 64'h11);
    exp[1] = mk(4'd6, OP_RDMA_WRITE, 64'hFFFF_FFFF_FFFF_F800, 64'hFFFF_FFFF_FFFF_FFFF, 13'd4096, 1'b1, 1'b0, 64'h22);
    exp[2] = mk(4'd6, OP_RDMA_WRITE, 64'h0000_0000_0000_0800, 64'h0000_0000_0000_0FFF, 13'd1, 1'b0, 1'b1, 64'h22);
    n_total++;
    if (got_q.size() - b != 3) $display("FAIL exact_mtu_count: got %0d required 3", got_q.size() - b);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (got_q.size() <= b + i || got_q[b+i] !== exp[i])
        $display("FAIL exact_mtu[%0d]: got %h required %h", i, (got_q.size() > b + i) ? got_q[b+i] : desc_t'('0), exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_zero_len();
    desc_t exp;
    int b;
    b = got_q.size();
    bus.i_pkt_rdy = 1'b1;
    push_wqe(64'h33, 64'h6000, 64'h5000, 32'd0, OP_RDMA_WRITE, 4'hF);
    wait_descs(b, 1);
    wait_idle();
    exp = mk(4'hF, OP_RDMA_WRITE, 64'h5000, 64'h6000, 13'd0, 1'b1, 1'b1, 64'h33);
    n_total++;
    if (got_q.size() - b != 1) $display("FAIL zero_len_count: got %0d required 1", got_q.size() - b);
    else n_pass++;
    n_total++;
    if (got_q.size() <= b || got_q[b] !== exp)
      $display("FAIL zero_len_desc: got %h required %h", (got_q.size() > b) ? got_q[b] : desc_t'('0), exp);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0 || state_dbg !== ST_IDLE)
      $display("FAIL zero_len_idle: got busy=%b state=%0d required busy=0 state=0", busy, state_dbg);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    desc_t exp[3];
    desc_t snap;
    int b, k;
    b = got_q.size();
    bus.i_pkt_rdy = 1'b0;
    push_wqe(64'h44, 64'h2_0000, 64'h1_0000, 32'd10000, OP_SEND, 4'd2);
    exp[0] = mk(4'd2, OP_SEND, 64'h1_0000, 64'h2_0000, 13'd4096, 1'b1, 1'b0, 64'h44);
    exp[1] = mk(4'd2, OP_SEND, 64'h1_1000, 64'h2_1000, 13'd4096, 1'b0, 1'b0, 64'h44);
    exp[2] = mk(4'd2, OP_SEND, 64'h1_2000, 64'h2_2000, 13'd1808, 1'b0, 1'b1, 64'h44);
    k = 0;
    while (!bus.o_pkt_val && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #1 bus.i_pkt_rdy = 1'b1;
    @(posedge clk); #1 bus.i_pkt_rdy = 1'b0;
    @(negedge clk);
    snap = cur_desc();
    n_total++;
    if (snap !== exp[1]) $display("FAIL bp_hold_start: got %h required %h", snap, exp[1]);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_total++;
      if (bus.o_pkt_val !== 1'b1 || cur_desc() !== exp[1])
        $display("FAIL bp_hold[%0d]: got val=%b %h required val=1 %h", i, bus.o_pkt_val, cur_desc(), exp[1]);
      else n_pass++;
    end
    @(posedge clk); #1 bus.i_pkt_rdy = 1'b1;
    wait_descs(b, 3);
    wait_idle();
    n_total++;
    if (got_q.size() - b != 3) $display("FAIL bp_count: got %0d required 3", got_q.size() - b);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (got_q.size() <= b + i || got_q[b+i] !== exp[i])
        $display("FAIL bp[%0d]: got %h required %h", i, (got_q.size() > b + i) ? got_q[b+i] : desc_t'('0), exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    desc_t exp[3];
    int b, rb, lb;
    b  = got_q.size();
    rb = rd_cycles.size();
    lb = last_cycles.size();
    bus.i_pkt_rdy = 1'b1;
    push_wqe(64'h55, 64'h9000, 64'h7000, 32'd5000, OP_SEND, 4'd1);
    push_wqe(64'h66, 64'hB000, 64'hA000, 32'd100, OP_RDMA_WRITE, 4'd9);
    wait_descs(b, 3);
    wait_idle();
    exp[0] = mk(4'd1, OP_SEND, 64'h7000, 64'h9000, 13'd4096, 1'b1, 1'b0, 64'h55);
    exp[1] = mk(4'd1, OP_SEND, 64'h8000, 64'hA000, 13'd904, 1'b0, 1'b1, 64'h55);
    exp[2] = mk(4'd9, OP_RDMA_WRITE, 64'hA000, 64'hB000, 13'd100, 1'b1, 1'b1, 64'h66);
    n_total++;
    if (got_q.size() - b != 3) $display("FAIL b2b_count: got %0d required 3", got_q.size() - b);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (got_q.size() <= b + i || got_q[b+i] !== exp[i])
        $display("FAIL b2b[%0d]: got %h required %h", i, (got_q.size() > b + i) ? got_q[b+i] : desc_t'('0), exp[i]);
      else n_pass++;
    end
    n_total++;
    if (rd_cycles.size() - rb != 2) $display("FAIL b2b_reads: got %0d required 2", rd_cycles.size() - rb);
    else n_pass++;
    // Last handshake, one IDLE cycle, then the registered read strobe.
    n_total++;
    if (rd_cycles.size() < rb + 2 || last_cycles.size() <= lb ||
        rd_cycles[rb+1] != last_cycles[lb] + 2)
      $display("FAIL b2b_read_timing: got rd@%0d last@%0d required rd = last+2",
               (rd_cycles.size() >= rb + 2) ? rd_cycles[rb+1] : -1,
               (last_cycles.size() > lb) ? last_cycles[lb] : -1);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    desc_t exp;
    int b, rb, k;
    b  = got_q.size();
    rb = rd_cycles.size();
    bus.i_pkt_rdy = 1'b0;
    push_wqe(64'h77, 64'h3000, 64'h1000, 32'd10000, OP_SEND, 4'd4);
    k = 0;
    while (!bus.o_pkt_val && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.o_pkt_val, bus.o_wqe_cache_rd, busy} !== 3'b000 || cur_desc() !== desc_t'('0))
      $display("FAIL reset_mid_async: got val/rd/busy=%b fields=%h required all 0",
               {bus.o_pkt_val, bus.o_wqe_cache_rd, busy}, cur_desc());
    else n_pass++;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_total++;
    if (rd_cycles.size() - rb != 1 || busy !== 1'b0 || state_dbg !== ST_IDLE)
      $display("FAIL reset_mid_idle: got reads=%0d busy=%b state=%0d required 1 0 0",
               rd_cycles.size() - rb, busy, state_dbg);
    else n_pass++;
    n_total++;
    if (got_q.size() != b) $display("FAIL reset_mid_dropped: got %0d descriptors required 0", got_q.size() - b);
    else n_pass++;
    @(posedge clk); #1 bus.i_pkt_rdy = 1'b1;
    push_wqe(64'h88, 64'hD000, 64'hC000, 32'd10, OP_SEND, 4'd7);
    wait_descs(b, 1);
    wait_idle();
    exp = mk(4'd7, OP_SEND, 64'hC000, 64'hD000, 13'd10, 1'b1, 1'b1, 64'h88);
    n_total++;
    if (got_q.size() <= b || got_q[b] !== exp)
      $display("FAIL reset_mid_next: got %h required %h", (got_q.size() > b) ? got_q[b] : desc_t'('0), exp);
    else n_pass++;
    n_total++;
    if (rd_cycles.size() - rb != 2) $display("FAIL reset_mid_reads: got %0d required 2", rd_cycles.size() - rb);
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_total++;
    if (rd_cycles.size() != 0) $display("FAIL idle_no_read: got %0d reads required 0", rd_cycles.size());
    else n_pass++;
    test_multi_seg();
    test_exact_mtu();
    test_zero_len();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    n_total++;
    if (wait_err != 0) $display("FAIL wait_timeout: got WAIT > 3 cycles required data after 1 cycle");
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
